murmur3_stream: RTL and testbench
=================================

MURMUR3_STREAM -- requirements
Module: murmur3_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter LEN_W, default 32, SHALL set the byte-length counter width (range 32..64).
REQ-003 Port clk SHALL be a 1-bit input clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be a 1-bit input reset, synchronous, active-high.
REQ-005 Port seed SHALL be a 32-bit input: hash seed, sampled on the first accepted beat of a message.
REQ-006 Port chunk SHALL be a 32-bit input data word, little-endian: byte0 = chunk[7:0], byte3 = chunk[31:24].
REQ-007 Port in_bytes SHALL be a 3-bit input: valid byte count of the beat, 0..4.
REQ-008 Port in_last SHALL be a 1-bit input that marks the final beat of a message.
REQ-009 Port in_valid SHALL be a 1-bit input; port in_ready SHALL be a 1-bit output; a beat is accepted when both are high.
REQ-010 Port hash SHALL be a 32-bit output: MurmurHash3 x86_32 of the message.
REQ-011 Port hash_valid SHALL be a 1-bit output; port hash_ready SHALL be a 1-bit input; the result is consumed when both are high.
REQ-012 Port proto_err SHALL be a 1-bit output: sticky protocol-error flag.

Function
REQ-013 States SHALL be IDLE, BODY, FIN1, FIN2 and OUT; in_ready SHALL be 1 only in IDLE and BODY.
REQ-014 On an accepted beat in IDLE, h SHALL load seed before mixing, and the length counter SHALL clear before adding.
REQ-015 A non-last beat SHALL mix chunk as a full block: k*=0xCC9E2D51; k=rotl(k,15); k*=0x1B873593; h^=k; h=rotl(h,13); h=h*5+0xE6546B64, with all arithmetic mod 2^32.
REQ-016 A last beat with in_bytes=4 SHALL apply the full-block mix.
REQ-017 A last beat with in_bytes=1..3 SHALL apply the tail mix to the low in_bytes bytes, zero-extended: k*=c1; rotl15; k*=c2; h^=k, with no h rotate or multiply.
REQ-018 A last beat with in_bytes=0 SHALL leave h unmixed.
REQ-019 Every accepted beat SHALL add in_bytes to the length counter; the counter SHALL wrap mod 2^LEN_W.
REQ-020 On an accepted last beat, the register update SHALL also apply h^=len[31:0], and the next state SHALL be FIN1; on a non-last beat the next state SHALL be BODY.
REQ-021 FIN1 SHALL compute h=(h^(h>>16))*0x85EBCA6B.
REQ-022 FIN2 SHALL compute h^=h>>13; h*=0xC2B2AE35; h^=h>>16.
REQ-023 After FIN2 the state SHALL be OUT.
REQ-024 Latency: if the last beat is accepted in cycle T, hash_valid SHALL rise in cycle T+3.
REQ-025 In OUT, hash and hash_valid SHALL hold stable until hash_ready is high; after the handshake the next state SHALL be IDLE.
REQ-026 A new message's first beat SHALL be accepted no earlier than the cycle after the output handshake.
REQ-027 While in_valid is low, or in FIN1, FIN2 or OUT, h and the length counter SHALL be unchanged.
REQ-028 Messages with zero total length (a single last beat with in_bytes=0) SHALL be legal.

Reset
REQ-029 When rst is high at a clock edge: state=IDLE, h=0, len=0, hash=0, hash_valid=0, proto_err=0; in_ready SHALL be 1 in the following cycle.
REQ-030 Reset asserted mid-message, or in FIN or OUT, SHALL discard the message with no partial hash output; rst SHALL take priority over any simultaneous handshake.

Configuration
REQ-031 Macro MURMUR3_PROTO_CHECK_EN defined: an accepted non-last beat with in_bytes!=4, or any beat with in_bytes>4, SHALL set proto_err, which holds until rst; the beat is processed as if in_bytes=4.
REQ-032 Macro MURMUR3_PROTO_CHECK_EN undefined: proto_err SHALL be tied to 0, and non-last beats SHALL be treated as in_bytes=4 without checking.

Verification
REQ-033 seed=0x00000000, one beat with in_last=1 and in_bytes=0 -> hash=0x00000000 at T+3.
REQ-034 seed=0x00000001, one beat with in_last=1 and in_bytes=0 -> hash=0x514E28B7.
REQ-035 seed=0x00000000, chunk=0x74736574 ("test"), in_bytes=4, in_last=1 -> hash=0xBA6BD213.
REQ-036 seed=0x000004D2, "Hello, world!" as 4 beats (0x6C6C6548, 0x77202C6F, 0x646C726F, last 0x00000021 with in_bytes=1) -> hash=0xFAF6CDB3.
REQ-037 Hold hash_ready=0 for 10 cycles after hash_valid -> hash stable and in_ready=0 throughout; handshake then a back-to-back second message -> first beat accepted the next cycle.
REQ-038 Assert rst in BODY after 2 beats, then send "test" with seed 0 -> hash=0xBA6BD213; with the macro defined, a non-last beat with in_bytes=2 -> proto_err=1 until rst.

Source files
------------

// File: rtl/murmur3_stream.sv
// Streaming MurmurHash3 x86_32: one 32-bit little-endian beat per cycle, result 3 cycles after the last beat.
// in_ready drops from last beat until the hash handshake. MURMUR3_PROTO_CHECK_EN enables the sticky proto_err flag.
module murmur3_stream #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic [31:0] chunk,
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] hash,
  output logic        hash_valid,
  input  logic        hash_ready,
  output logic        proto_err
);
  localparam logic [31:0] C1 = 32'hCC9E2D51;
  localparam logic [31:0] C2 = 32'h1B873593;
  localparam logic [31:0] C3 = 32'hE6546B64;
  localparam logic [31:0] F1 = 32'h85EBCA6B;
  localparam logic [31:0] F2 = 32'hC2B2AE35;

  typedef enum logic [2:0] {IDLE, BODY, FIN1, FIN2, OUT} state_t;

  state_t           state, state_nxt;
  logic [31:0]      h, h_nxt;
  logic [LEN_W-1:0] len, len_nxt;

  logic             accept;
  logic [2:0]       eff_bytes;
  logic [31:0]      k_mask, k1, k2;
  logic [31:0]      h_base, h_xk, h_rot, h_full, h_mixed, h_beat;
  logic [31:0]      fin1, f2a, f2b, fin2;
  logic [LEN_W-1:0] len_base, len_sum;

  assign in_ready   = (state == IDLE) || (state == BODY);
  assign accept     = in_valid && in_ready;
  assign hash       = h;
  assign hash_valid = (state == OUT);

  // Only the last beat may be short; anything else is hashed as a full word.
  assign eff_bytes = (!in_last || (in_bytes > 3'd4)) ? 3'd4 : in_bytes;

  always_comb begin
    k_mask = 32'h0;
    case (eff_bytes)
      3'd1:    k_mask = {24'h0, chunk[7:0]};
      3'd2:    k_mask = {16'h0, chunk[15:0]};
      3'd3:    k_mask = {8'h0, chunk[23:0]};
      3'd4:    k_mask = chunk;
      default: k_mask = 32'h0;
    endcase
  end

  assign k1       = k_mask * C1;
  assign k2       = {k1[16:0], k1[31:17]} * C2;
  assign h_base   = (state == IDLE) ? seed : h;
  assign h_xk     = h_base ^ k2;
  assign h_rot    = {h_xk[18:0], h_xk[31:19]};
  assign h_full   = h_rot * 32'd5 + C3;
  assign len_base = (state == IDLE) ? '0 : len;
  assign len_sum  = len_base + {{(LEN_W-3){1'b0}}, eff_bytes};

  always_comb begin
    h_mixed = h_xk;
    if (eff_bytes == 3'd0)      h_mixed = h_base;
    else if (eff_bytes == 3'd4) h_mixed = h_full;
  end

  assign h_beat = in_last ? (h_mixed ^ len_sum[31:0]) : h_mixed;

  assign fin1 = (h ^ (h >> 16)) * F1;
  assign f2a  = h ^ (h >> 13);
  assign f2b  = f2a * F2;
  assign fin2 = f2b ^ (f2b >> 16);

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    len_nxt   = len;
    case (state)
      IDLE, BODY: begin
        if (accept) begin
          h_nxt     = h_beat;
          len_nxt   = len_sum;
          state_nxt = in_last ? FIN1 : BODY;
        end
      end
      FIN1: begin
        h_nxt     = fin1;
        state_nxt = FIN2;
      end
      FIN2: begin
        h_nxt     = fin2;
        state_nxt = OUT;
      end
      OUT: begin
        if (hash_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      h     <= 32'h0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      len   <= len_nxt;
    end
  end

`ifdef MURMUR3_PROTO_CHECK_EN
  logic bad_beat;
  logic proto_err_q;

  assign bad_beat  = (in_bytes > 3'd4) || (!in_last && (in_bytes != 3'd4));
  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst)                      proto_err_q <= 1'b0;
    else if (accept && bad_beat)  proto_err_q <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_murmur3_stream.sv
// Self-checking bench for murmur3_stream against a byte-array MurmurHash3 reference model.
module tb_murmur3_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seed, chunk;
  logic [2:0]  in_bytes;
  logic        in_last, in_valid, in_ready;
  logic [31:0] hash;
  logic        hash_valid, hash_ready, proto_err;

  int checks = 0;
  int fails  = 0;

  murmur3_stream #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .seed(seed), .chunk(chunk), .in_bytes(in_bytes),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .hash(hash),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_hash(input logic [31:0] s, input byte unsigned m[$]);
    logic [31:0] h, k;
    int n, nblk, rem;
    n = m.size();
    h = s;
    nblk = n / 4;
    for (int b = 0; b < nblk; b++) begin
      k = {m[4*b+3], m[4*b+2], m[4*b+1], m[4*b]};
      k = k * 32'hCC9E2D51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1B873593;
      h = h ^ k;
      h = (h << 13) | (h >> 19);
      h = h * 32'd5 + 32'hE6546B64;
    end
    rem = n % 4;
    if (rem > 0) begin
      k = 32'h0;
      for (int j = rem - 1; j >= 0; j--) k = (k << 8) | {24'h0, m[4*nblk+j]};
      k = k * 32'hCC9E2D51;
      k = (k << 15) | (k >> 17);
      k = k * 32'h1B873593;
      h = h ^ k;
    end
    h = h ^ 32'(n);
    h = h ^ (h >> 16);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2AE35;
    h = h ^ (h >> 16);
    return h;
  endfunction

  // Drives one message, waits for the result, holds hash_ready low for 'hold' cycles, then handshakes.
  task automatic send_msg(input logic [31:0] s, input byte unsigned m[$], input bit ztail,
                          input bit gaps, input int hold, output int first_wait, output int lat,
                          output logic [31:0] got, output int hold_bad, output bit rdy_after);
    int n, nb, idx, cnt, w;
    logic [31:0] word;
    n  = m.size();
    nb = (n + 3) / 4;
    if (n == 0 || (n % 4 == 0 && ztail)) nb++;
    idx = 0;
    first_wait = 0;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        chunk    = $urandom();
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      cnt = n - idx;
      if (cnt > 4) cnt = 4;
      word = $urandom();
      for (int j = 0; j < cnt; j++) word[8*j +: 8] = m[idx+j];
      idx += cnt;
      seed     = (b == 0) ? s : $urandom();
      chunk    = word;
      in_bytes = 3'(cnt);
      in_last  = (b == nb - 1);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (b == 0) first_wait = w;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chunk    = $urandom();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!hash_valid && lat < 20);
    got = hash;
    hold_bad = 0;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      chunk    = $urandom();
      in_last  = 1'b1;
      in_bytes = 3'd4;
      @(negedge clk);
      if (hash !== got || hash_valid !== 1'b1 || in_ready !== 1'b0) hold_bad++;
    end
    in_valid   = 1'b0;
    hash_ready = 1'b1;
    @(posedge clk);
    #1;
    hash_ready = 1'b0;
    rdy_after  = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; hash_ready = 1'b0;
    seed = 32'h0; chunk = 32'h0; in_bytes = 3'd0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (hash !== 32'h0)       begin fails++; $display("FAIL reset_hash got=%h exp=0", hash); end
    checks++; if (hash_valid !== 1'b0)  begin fails++; $display("FAIL reset_hash_valid got=%b exp=0", hash_valid); end
    checks++; if (proto_err !== 1'b0)   begin fails++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    checks++; if (in_ready !== 1'b1)    begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    byte unsigned q[$];
    string str;
    int fw, lat, hb;
    logic [31:0] got;
    bit ra;
    q = {};
    send_msg(32'h0, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (got !== 32'h00000000) begin fails++; $display("FAIL vec_empty_seed0 got=%h exp=00000000", got); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL vec_empty_latency got=%0d exp=3", lat); end
    send_msg(32'h1, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (got !== 32'h514E28B7) begin fails++; $display("FAIL vec_empty_seed1 got=%h exp=514e28b7", got); end
    str = "test";
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    send_msg(32'h0, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (got !== 32'hBA6BD213) begin fails++; $display("FAIL vec_test got=%h exp=ba6bd213", got); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL vec_test_latency got=%0d exp=3", lat); end
    q = {};
    str = "Hello, world!";
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    send_msg(32'h4D2, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (got !== 32'hFAF6CDB3) begin fails++; $display("FAIL vec_hello got=%h exp=faf6cdb3", got); end
  endtask

  task automatic test_random();
    byte unsigned q[$];
    int fw, lat, hb, n;
    logic [31:0] got, s, exp;
    bit ra;
    for (int t = 0; t < 40; t++) begin
      q = {};
      n = $urandom_range(0, 23);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
      s = $urandom();
      exp = ref_hash(s, q);
      send_msg(s, q, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 3), fw, lat, got, hb, ra);
      checks++; if (got !== exp) begin fails++; $display("FAIL rand_hash[%0d] len=%0d got=%h exp=%h", t, n, got, exp); end
      checks++; if (lat !== 3) begin fails++; $display("FAIL rand_latency[%0d] got=%0d exp=3", t, lat); end
    end
  endtask

  task automatic test_back_to_back();
    byte unsigned q[$];
    int fw, lat, hb;
    logic [31:0] got, s, exp;
    bit ra;
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'($urandom()));
    s = $urandom();
    exp = ref_hash(s, q);
    send_msg(s, q, 1'b0, 1'b0, 10, fw, lat, got, hb, ra);
    checks++; if (hb !== 0) begin fails++; $display("FAIL hold_stable bad_cycles=%0d exp=0", hb); end
    checks++; if (got !== exp) begin fails++; $display("FAIL hold_hash got=%h exp=%h", got, exp); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL ready_after_handshake got=%b exp=1", ra); end
    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom()));
    s = $urandom();
    exp = ref_hash(s, q);
    send_msg(s, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (fw !== 0) begin fails++; $display("FAIL b2b_first_beat_wait got=%0d exp=0", fw); end
    checks++; if (got !== exp) begin fails++; $display("FAIL b2b_hash got=%h exp=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    byte unsigned q[$];
    string str;
    int fw, lat, hb, bad;
    logic [31:0] got;
    bit ra;
    @(negedge clk);
    seed = 32'h1111; chunk = $urandom(); in_bytes = 3'd4; in_last = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; in_last = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || hash_valid !== 1'b0)
      begin fails++; $display("FAIL rst_body in_ready=%b hash_valid=%b exp 1/0", in_ready, hash_valid); end
    str = "test";
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    send_msg(32'h0, q, 1'b0, 1'b0, 0, fw, lat, got, hb, ra);
    checks++; if (got !== 32'hBA6BD213) begin fails++; $display("FAIL rst_body_then_test got=%h exp=ba6bd213", got); end
    // reset while the result is presented, racing a handshake
    @(negedge clk);
    seed = $urandom(); chunk = $urandom(); in_bytes = 3'd4; in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hash_valid !== 1'b1) begin fails++; $display("FAIL out_reached got=%b exp=1", hash_valid); end
    rst = 1'b1; hash_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; hash_ready = 1'b0;
    @(negedge clk);
    checks++; if (hash_valid !== 1'b0 || hash !== 32'h0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL rst_out valid=%b hash=%h in_ready=%b exp 0/0/1", hash_valid, hash, in_ready); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (hash_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL rst_out_no_partial valid_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_proto();
    byte unsigned q[$];
    logic [31:0] w1, w2, s, exp;
    int lat;
    w1 = $urandom(); w2 = $urandom(); s = $urandom();
    for (int j = 0; j < 4; j++) q.push_back(w1[8*j +: 8]);
    for (int j = 0; j < 4; j++) q.push_back(w2[8*j +: 8]);
    exp = ref_hash(s, q);
    @(negedge clk);
    seed = s; chunk = w1; in_bytes = 3'd2; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    seed = $urandom(); chunk = w2; in_bytes = 3'd4; in_last = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!hash_valid && lat < 20);
    checks++; if (hash !== exp) begin fails++; $display("FAIL short_nonlast_hash got=%h exp=%h", hash, exp); end
`ifdef MURMUR3_PROTO_CHECK_EN
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_set got=%b exp=1", proto_err); end
    hash_ready = 1'b1;
    @(posedge clk);
    #1 hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin fails++; $display("FAIL proto_err_sticky got=%b exp=1", proto_err); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL proto_err_clear got=%b exp=0", proto_err); end
`else
    checks++; if (proto_err !== 1'b0) begin fails++; $display("FAIL proto_err_tied got=%b exp=0", proto_err); end
    hash_ready = 1'b1;
    @(posedge clk);
    #1 hash_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_proto();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
